// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single-port SRAM
// with a fixed read latency. One access is in flight at a time; requests are
// only sampled while idle.
module mem_arbiter #(
  parameter int RD_LAT = 2              // mem_cs to mem_rdata valid, 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [11:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [11:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int PORT_F = 0;
  localparam int PORT_D = 1;

  // Latched access, captured once when the winner is chosen.
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic             win;       // 0 = fetch, 1 = data
  logic             last;      // port granted most recently
  acc_t             acc;
  logic             pick;
  logic [1:0][15:0] rdata_q;   // per-port read data hold registers
  logic             issue;
  logic             resp;

  // Round-robin pick: a lone requester wins, a tie goes to the port not
  // granted last time.
  always_comb begin
    pick = 1'b0;
    if (f_req && d_req) pick = ~last;
    else                pick = d_req;
  end

  // Access FSM, latency counter, winner latch and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      win     <= 1'b0;
      last    <= 1'b1;           // data counts as last so fetch wins the first tie
      acc     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (f_req || d_req) begin
            win       <= pick;
            last      <= pick;
            acc.we    <= pick & d_we;
            acc.addr  <= pick ? d_addr  : f_addr;
            acc.wdata <= pick ? d_wdata : 16'h0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (acc.we) begin
            state <= S_IDLE;
          end else begin
            cnt   <= 3'd1;       // first WAIT cycle is ISSUE+1
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // cnt == RD_LAT marks cycle ISSUE+RD_LAT, when mem_rdata is valid
          if (cnt == 3'(RD_LAT)) begin
            rdata_q[win] <= mem_rdata;
            cnt          <= 3'd0;
            state        <= S_RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;  // S_RESP
      endcase
    end
  end

  assign issue = (state == S_ISSUE);
  assign resp  = (state == S_RESP);

  // SRAM side is forced to zero outside the chip-select cycle.
  assign mem_cs    = issue;
  assign mem_we    = issue & acc.we;
  assign mem_addr  = issue ? acc.addr  : 12'h0;
  assign mem_wdata = issue ? acc.wdata : 16'h0;

  assign f_gnt    = issue & (win == 1'(PORT_F));
  assign d_gnt    = issue & (win == 1'(PORT_D));
  assign f_rvalid = resp  & (win == 1'(PORT_F));
  assign d_rvalid = resp  & (win == 1'(PORT_D));
  assign f_rdata  = rdata_q[PORT_F];
  assign d_rdata  = rdata_q[PORT_D];
  assign busy     = (state != S_IDLE);

endmodule
